// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster timing types and constants
//
// Purpose: state encoding for the raster FSM, default timing sets
//          (1440x900@60 for the board, 640x480@60 for quicker runs) and
//          a helper that sums the four segments of a line or a frame.
// Ports:   none (package).
package vga_timing_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  // 1440x900@60, 106.5 MHz pixel clock
  localparam int WXGA_H_ACTIVE = 1440;
  localparam int WXGA_H_FP     = 80;
  localparam int WXGA_H_SYNC   = 152;
  localparam int WXGA_H_BP     = 232;
  localparam int WXGA_V_ACTIVE = 900;
  localparam int WXGA_V_FP     = 3;
  localparam int WXGA_V_SYNC   = 6;
  localparam int WXGA_V_BP     = 25;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer
//
// Purpose: brings an asynchronous level (e.g. a PLL flag) into the clk
//          domain. Both flops clear on reset so the output reads 0 until
//          the input has been seen high on two consecutive edges.
// Ports:   clk  - destination clock
//          rst  - asynchronous active-high reset
//          i_d  - asynchronous input level
//          o_q  - synchronized level
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator gated by PLL lock
//
// Purpose: waits for a stable PLL lock, then walks hc/vc over the full
//          raster and decodes registered sync, data-enable, coordinates
//          and strobes (one cycle behind the counters).
// Ports:   clk         - pixel clock
//          rst         - asynchronous active-high reset
//          pll_locked  - raw PLL locked flag (asynchronous, may glitch)
//          hsync/vsync - syncs, at HSYNC_POL/VSYNC_POL inside the window
//          de          - visible-pixel enable
//          x/y         - pixel column / line, aligned with de and syncs
//          line_start  - pulse when x==0
//          frame_start - pulse when x==0 and y==0
//          running     - high while the raster is being driven
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = WXGA_H_ACTIVE,
  parameter int   H_FP       = WXGA_H_FP,
  parameter int   H_SYNC     = WXGA_H_SYNC,
  parameter int   H_BP       = WXGA_H_BP,
  parameter int   V_ACTIVE   = WXGA_V_ACTIVE,
  parameter int   V_FP       = WXGA_V_FP,
  parameter int   V_SYNC     = WXGA_V_SYNC,
  parameter int   V_BP       = WXGA_V_BP,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b1,
  parameter int   SETTLE_CYC = 16,
  parameter int   CW         = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int SW      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  state_t        r_state;
  logic [SW-1:0] r_settle;
  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;

  logic r_hsync, r_vsync, r_de, r_ls, r_fs, r_run;
  logic [CW-1:0] r_x, r_y;

  logic w_lk;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_active;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_lk)
  );

  assign w_h_wrap = (r_hc == H_LAST);
  assign w_v_wrap = (r_vc == V_LAST);
  // Gating on w_lk as well as RUN makes the outputs go idle on the same
  // edge that abandons the frame, instead of showing one stale pixel.
  assign w_active = (r_state == RUN) && w_lk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= WAIT_LOCK;
      r_settle <= '0;
      r_hc     <= '0;
      r_vc     <= '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_hc <= '0;
          r_vc <= '0;
          if (w_lk) begin
            r_settle <= '0;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (!w_lk) begin
            r_state <= WAIT_LOCK;
          end else if (r_settle == SET_LAST) begin
            r_hc    <= '0;
            r_vc    <= '0;
            r_state <= RUN;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        RUN: begin
          if (!w_lk) begin
            // No partial-line completion: the raster restarts at (0,0).
            r_hc    <= '0;
            r_vc    <= '0;
            r_state <= WAIT_LOCK;
          end else if (w_h_wrap) begin
            r_hc <= '0;
            r_vc <= w_v_wrap ? '0 : r_vc + 1'b1;
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        default: r_state <= WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
      r_run   <= 1'b0;
    end else if (w_active) begin
      r_hsync <= ((r_hc >= HS_BEG) && (r_hc < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      // vc only moves on the hc wrap, so vsync flips with the x==0 pixel.
      r_vsync <= ((r_vc >= VS_BEG) && (r_vc < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      r_de    <= (r_hc < H_ACT_C) && (r_vc < V_ACT_C);
      r_x     <= r_hc;
      r_y     <= r_vc;
      r_ls    <= (r_hc == '0);
      r_fs    <= (r_hc == '0) && (r_vc == '0);
      r_run   <= 1'b1;
    end else begin
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
      r_run   <= 1'b0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign running     = r_run;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen on a small raster
module tb_vga_timing_gen;

  // Small raster: line = 8+2+2+2 = 14 pixels, frame = 4+1+1+1 = 7 lines.
  localparam int CW = 11;
  localparam int HT = 14;
  localparam int FT = 98;
  localparam int SA = 8;
  localparam int SB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;

  logic a_hs, a_vs, a_de, a_ls, a_fs, a_run;
  logic b_hs, b_vs, b_de, b_ls, b_fs, b_run;
  logic [CW-1:0] a_x, a_y, b_x, b_y;

  int checks = 0;
  int errors = 0;

  // Expected output index since the raster started (-1 = idle), lock
  // bring-up countdowns and lock-loss countdowns, one set per instance.
  int ka = -1, kb = -1;
  int cda = 0, cdb = 0;
  int lca = 0, lcb = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .SETTLE_CYC(SA), .CW(CW)
  ) u_dut_a (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs), .running(a_run)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .SETTLE_CYC(SB), .CW(CW)
  ) u_dut_b (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs), .running(b_run)
  );

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Hand-derived decode of the small raster: de on x<8,y<4; hsync low on
  // x=10,11; vsync high on y=5.
  task automatic check_out(input string n, input int k,
                           input logic hs, input logic vs, input logic de,
                           input logic ls, input logic fs, input logic run,
                           input logic [CW-1:0] xo, input logic [CW-1:0] yo);
    int hc = 0;
    int vc = 0;
    int ehs = 1, evs = 0, ede = 0, els = 0, efs = 0, erun = 0;
    if (k >= 0) begin
      hc   = k % HT;
      vc   = (k % FT) / HT;
      ede  = (hc < 8 && vc < 4) ? 1 : 0;
      ehs  = (hc == 10 || hc == 11) ? 0 : 1;
      evs  = (vc == 5) ? 1 : 0;
      els  = (hc == 0) ? 1 : 0;
      efs  = (hc == 0 && vc == 0) ? 1 : 0;
      erun = 1;
    end
    chk({n, ".hsync"}, hs, ehs);
    chk({n, ".vsync"}, vs, evs);
    chk({n, ".de"}, de, ede);
    chk({n, ".x"}, xo, hc);
    chk({n, ".y"}, yo, vc);
    chk({n, ".line_start"}, ls, els);
    chk({n, ".frame_start"}, fs, efs);
    chk({n, ".running"}, run, erun);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (lca > 0) begin lca--; if (lca == 0) ka = -1; end
    if (lcb > 0) begin lcb--; if (lcb == 0) kb = -1; end
    if (ka >= 0) ka++;
    if (kb >= 0) kb++;
    if (cda > 0) begin cda--; if (cda == 0) ka = 0; end
    if (cdb > 0) begin cdb--; if (cdb == 0) kb = 0; end
    check_out("a", ka, a_hs, a_vs, a_de, a_ls, a_fs, a_run, a_x, a_y);
    check_out("b", kb, b_hs, b_vs, b_de, b_ls, b_fs, b_run, b_x, b_y);
  endtask

  // Rising lock: outputs start 2 sync + SETTLE_CYC + 1 decode edges after
  // the first sample. Falling lock: outputs idle on the third edge.
  task automatic set_lock(input logic v);
    pll_locked = v;
    if (v) begin
      cda = SA + 4;
      cdb = SB + 4;
    end else begin
      cda = 0;
      cdb = 0;
      lca = 3;
      lcb = 3;
    end
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();

    // Bring-up with a one-sample glitch while instance a is at settle count 5
    set_lock(1'b1);
    repeat (6) step();
    set_lock(1'b0);
    step();
    set_lock(1'b1);
    repeat (11) step();
    chk("a.not_yet_running", a_run, 0);
    step();
    chk("a.first_frame_start", a_fs, 1);

    // Two full frames plus change, covering line and frame wraps
    repeat (2 * FT + 10) step();

    // Mid-line loss of lock at x=5, y=2
    n = 0;
    while (!(ka >= 0 && (ka % FT) == 2 * HT + 5) && n < 200) begin
      step();
      n++;
    end
    chk("wait_x5_y2", (n < 200) ? 1 : 0, 1);
    chk("loss.x", a_x, 5);
    set_lock(1'b0);
    repeat (3) step();
    chk("loss.de_idle", a_de, 0);
    chk("loss.hsync_idle", a_hs, 1);
    repeat (5) step();
    set_lock(1'b1);
    repeat (SA + 4) step();
    chk("relock.x", a_x, 0);
    chk("relock.y", a_y, 0);
    repeat (FT + 20) step();

    // Asynchronous reset mid-frame
    #2;
    rst = 1'b1;
    #1;
    chk("arst.running", a_run, 0);
    chk("arst.hsync", a_hs, 1);
    chk("arst.b_running", b_run, 0);
    ka = -1; kb = -1; cda = 0; cdb = 0; lca = 0; lcb = 0;
    repeat (3) step();
    rst = 1'b0;
    cda = SA + 4;
    cdb = SB + 4;
    repeat (SA + 3) step();
    chk("arst.a_still_idle", a_run, 0);
    repeat (30) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the pong display path, clocked by the 106.5 MHz pixel clock from the PLL.
- Consumes the PLL `locked` flag and holds the raster idle until the clock is stable.
- Produces hsync, vsync, data-enable, pixel coordinates and frame/line strobes for the pixel renderer and the VGA pins.
- Defaults are 1440x900@60 timing.

Parameters:
- H_ACTIVE, 1440, visible pixels per line
- H_FP, 80, horizontal front porch (pixels)
- H_SYNC, 152, hsync pulse width (pixels)
- H_BP, 232, horizontal back porch (pixels)
- V_ACTIVE, 900, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 25, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 1, asserted level of vsync
- SETTLE_CYC, 16, clk cycles `locked` must stay high before the raster starts (>=1)
- CW, 11, width of the coordinate and counter buses

Ports:
- clk, input, 1, pixel clock (PLL outclk_0)
- rst, input, 1, asynchronous active-high reset
- pll_locked, input, 1, PLL locked flag; asynchronous to clk and may glitch
- hsync, output, 1, horizontal sync at HSYNC_POL during the sync window
- vsync, output, 1, vertical sync at VSYNC_POL during the sync window
- de, output, 1, high for visible pixels
- x, output, CW, pixel column, 0..H_TOTAL-1
- y, output, CW, line number, 0..V_TOTAL-1
- line_start, output, 1, one-cycle pulse when x==0
- frame_start, output, 1, one-cycle pulse when x==0 and y==0
- running, output, 1, high while in RUN

Behaviour:
- One clock domain, clk. Reset rst is asynchronous, active-high.
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1904); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (934).
- pll_locked passes through a 2-flop synchronizer; both flops reset to 0. Only the synchronized value lk is used.
- State machine, reset state WAIT_LOCK:
  - WAIT_LOCK: when lk==1, clear the settle counter and go to SETTLE.
  - SETTLE: increment the settle counter while lk==1. If lk==0, go back to WAIT_LOCK. When the counter reaches SETTLE_CYC-1, clear hc/vc and go to RUN.
  - RUN: counters advance. If lk==0, go to WAIT_LOCK immediately.
- Counters hc and vc, each CW bits:
  - hc increments every RUN cycle and wraps from H_TOTAL-1 to 0.
  - vc increments only when hc wraps, and wraps from V_TOTAL-1 to 0.
  - Both are held at 0 outside RUN.
- Decode (combinational on hc/vc, then registered; 1-cycle latency from counter to outputs):
  - de = (hc < H_ACTIVE) && (vc < V_ACTIVE)
  - hsync asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC
  - vsync asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, changing on the same clk edge as the hc wrap
  - x/y are registered copies of hc/vc, aligned with de and the syncs
  - line_start = (hc==0); frame_start = (hc==0 && vc==0)
- Outside RUN, and in the cycle after leaving RUN: hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, x=y=0, strobes 0, running=0.
- Reset values of all outputs are the idle values above (hsync=1, vsync=0 at defaults).
- First RUN cycle: hc=vc=0. One cycle later: x=0, y=0, de=1, line_start=1, frame_start=1, running=1.
- Loss of lock mid-frame:
  - The frame is abandoned; no partial-line completion.
  - On relock, the full SETTLE sequence repeats and the raster restarts at (0,0).
- rst asserted mid-operation: all state and outputs go to reset values asynchronously. Release is synchronous to clk through normal flop behaviour; the first possible RUN is at least 2+SETTLE_CYC cycles later.
- Every sync and de output comes straight from a flop, with no combinational path to the pins.

Decomposition:
- Shared package vga_timing_pkg:
  - state enum {WAIT_LOCK, SETTLE, RUN}
  - default timing constants for 1440x900@60 and 640x480@60 (for sim)
  - a function returning the totals
- One natural sub-module: sync_2ff (generic 2-flop bit synchronizer with async active-high reset), reused for other PLL-domain flags.

Test Plan:
- Lock bring-up: rst pulse; pll_locked rises at t0 -> running=1 and frame_start=1 exactly 2+SETTLE_CYC+1 clk after the first lk sample. Until then hsync=1, vsync=0, de=0.
- Line timing (defaults), measured at the outputs:
  - de high 1440 cycles per line
  - hsync low from x=1520 to x=1671 (152 cycles)
  - line_start period 1904 cycles
- Frame timing, measured at the outputs:
  - de lines 0..899
  - vsync high on lines 903..908 (6 lines), rising with the hsync-line wrap at x=0
  - frame_start period 1904*934 = 1778336 cycles
- Lock glitch: pll_locked low for 1 cycle during SETTLE at count 5 -> returns to WAIT_LOCK; the full SETTLE_CYC restarts; running is delayed accordingly.
- Lock loss mid-line at x=700, y=300 -> within 3 clk de=0 and syncs idle. After relock plus settle, the first frame_start is at x=0, y=0 (no resume at 701).
- Small-param run (H 8/2/2/2, V 4/1/1/1, SETTLE_CYC 1) -> full sequence x=0..13, y=0..6 checked cycle-by-cycle against a reference model, including both wraps.
